rb1_arbiter: RTL and testbench
==============================

RB1_ARBITER -- requirements
Module: rb1_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports req0 / req1, input, 1 bit each: requester n wants the bank (level, held for the whole burst).
REQ-004 SHALL have ports rw0 / rw1, input, 1 bit each: requester access type, 1 = read, 0 = write.
REQ-005 SHALL have ports a0 / a1, input, 5 bits each: requester bank address, 0..17 valid.
REQ-006 SHALL have ports d0 / d1, input, 8 bits each: requester write data.
REQ-007 SHALL have ports gnt0 / gnt1, output, 1 bit each, registered: requester n owns the bank this cycle.
REQ-008 SHALL have ports ack0 / ack1, output, 1 bit each, registered: pulse meaning read data for requester n is on q.
REQ-009 SHALL have port q, output, 8 bits: shared read data, equal to RB1_Q.
REQ-010 SHALL have port RB1_RW, output, 1 bit: bank strobe, 1 = read, 0 = write.
REQ-011 SHALL have port RB1_A, output, 5 bits: bank address.
REQ-012 SHALL have port RB1_D, output, 8 bits: bank write data.
REQ-013 SHALL have port RB1_Q, input, 8 bits: bank read data, valid one cycle after address.
REQ-014 SHALL have parameter BURST_MAX, default 18: maximum consecutive accesses per grant while the other requester waits.

Function
REQ-015 SHALL implement a state machine with states IDLE, OWN0 and OWN1.
REQ-016 SHALL hold a 1-bit last pointer naming the most recently granted requester, plus a 5-bit burst counter cnt.
REQ-017 SHALL, in IDLE with exactly one reqn high, enter OWNn at the next edge, assert gntn, and clear cnt.
REQ-018 SHALL, in IDLE with both requests high, grant the requester not named by last (round robin).
REQ-019 SHALL, in OWNn with gntn=1 and reqn=1, perform one access per cycle: RB1_RW=rwn, RB1_A=an, RB1_D=dn (combinational mux); cnt increments per access, saturating at BURST_MAX.
REQ-020 SHALL, in IDLE or when the owner's req is low, drive RB1_RW=1, RB1_A=0, RB1_D=0 (idle read; no write possible).
REQ-021 SHALL assert ackn for one cycle, the cycle after requester n made a read access; q carries that data in the ack cycle.
REQ-022 SHALL never pulse ackn for a write access.
REQ-023 SHALL, in OWNn when reqn falls, leave OWNn at the next edge: enter OWNm if reqm=1, else IDLE; last=n.
REQ-024 SHALL, in OWNn when cnt reaches BURST_MAX and reqm=1, force handover to OWNm at the next edge, even with reqn high; last=n; cnt cleared.
REQ-025 SHALL, in OWNn when cnt reaches BURST_MAX and reqm=0, keep the grant; cnt stays saturated.
REQ-026 SHALL hold gnt0 and gnt1 mutually exclusive in every cycle, with no idle cycle on a handover.
REQ-027 SHALL complete an ack owed for a read made in the last owned cycle, even after the grant has moved.
REQ-028 SHALL ignore a0/a1 values above 17 without checking; they pass through unmodified.

Reset
REQ-029 SHALL, while rst=1 at an edge, set state=IDLE, last=1, cnt=0, gnt0=gnt1=0, ack0=ack1=0, RB1_RW=1, RB1_A=0, RB1_D=0.
REQ-030 SHALL, on reset during a burst, drop the grant at that edge, lose any pending ack, and issue no write.
REQ-031 SHALL, after reset, give the first simultaneous request to requester 0.

Verification
REQ-032 SHALL verify: reset, then req0=req1=1 together -> gnt0=1 next cycle; gnt1=0.
REQ-033 SHALL verify: req0 reads a0=0..17 back-to-back, with bank preloaded as value = 8'h10 + address -> ack0 pulses 18 times; q=8'h10..8'h21 in order.
REQ-034 SHALL verify: req1 writes d1=8'hA5 to a1=3 -> RB1_RW=0 for exactly one cycle with RB1_A=3; later read returns 8'hA5.
REQ-035 SHALL verify: req0 held for 25 accesses with req1 high -> handover to gnt1 after the 18th access with no gap cycle; gnt0 returns after req1 drops.
REQ-036 SHALL verify: rst asserted mid-burst (cnt=7, write pending) -> gnt0=0, RB1_RW=1, state IDLE at that edge.
REQ-037 SHALL verify: ack is not lost on a handover read -> the last read by requester 0 before handover still pulses ack0 in the first gnt1 cycle.

Source files
------------

// File: rtl/rb1_arbiter.sv
// Two-requester round-robin arbiter for the RB1 bank.
// The owner gets one access per cycle. It keeps the bank until it drops
// its request, or until it has made BURST_MAX accesses while the other
// requester is waiting. The bank strobe is a combinational mux from the
// owner's inputs. A read returns data on q one cycle later, marked by ack.
//
// state | meaning
// IDLE  | nobody owns the bank; bank held in idle read at address 0
// OWN0  | requester 0 owns the bank
// OWN1  | requester 1 owns the bank
module rb1_arbiter #(
    parameter int BURST_MAX = 18
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rw0,
    input  logic       rw1,
    input  logic [4:0] a0,
    input  logic [4:0] a1,
    input  logic [7:0] d0,
    input  logic [7:0] d1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       ack0,
    output logic       ack1,
    output logic [7:0] q,
    output logic       RB1_RW,
    output logic [4:0] RB1_A,
    output logic [7:0] RB1_D,
    input  logic [7:0] RB1_Q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [4:0] CNT_MAX = 5'(BURST_MAX);

    state_t     state, state_nxt;
    logic       last, last_nxt;
    logic [4:0] cnt, cnt_nxt, cnt_acc;
    logic       sel1;
    logic       own_req;
    logic       oth_req;
    logic       access;

    // Decode who owns the bank. Also decide whether an access happens this cycle.
    // rst gates the access, so a reset cycle can never write to the bank.
    always_comb begin
        sel1    = (state == OWN1);
        own_req = ((state == OWN0) && req0) || ((state == OWN1) && req1);
        oth_req = sel1 ? req0 : req1;
        access  = own_req && !rst;
        cnt_acc = (access && (cnt != CNT_MAX)) ? cnt + 5'd1 : cnt;
    end

    // Next state, burst counting and the bank strobe mux.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt_acc;
        RB1_RW    = 1'b1;
        RB1_A     = 5'd0;
        RB1_D     = 8'd0;
        if (access) begin
            RB1_RW = sel1 ? rw1 : rw0;
            RB1_A  = sel1 ? a1  : a0;
            RB1_D  = sel1 ? d1  : d0;
        end
        case (state)
            IDLE: begin
                cnt_nxt = 5'd0;
                if (req0 && req1)
                    state_nxt = last ? OWN0 : OWN1;
                else if (req0)
                    state_nxt = OWN0;
                else if (req1)
                    state_nxt = OWN1;
            end
            OWN0, OWN1: begin
                // Release on request drop, or force handover once the burst is used up
                if (!own_req || (oth_req && (cnt_acc == CNT_MAX))) begin
                    last_nxt  = sel1;
                    cnt_nxt   = 5'd0;
                    state_nxt = oth_req ? (sel1 ? OWN0 : OWN1) : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 5'd0;
            end
        endcase
    end

    // State, pointer, counter and registered grant/ack outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
            cnt   <= 5'd0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            gnt0  <= (state_nxt == OWN0);
            gnt1  <= (state_nxt == OWN1);
            ack0  <= access && !sel1 && rw0;
            ack1  <= access && sel1 && rw1;
        end
    end

    assign q = RB1_Q;

endmodule

// File: tb/tb_rb1_arbiter.sv
// Scoreboard bench for rb1_arbiter.
// The driver runs a small arbitration model once per cycle.
// The model tracks the owner index, the burst count and a shadow memory.
// Expected per-cycle outputs go into one queue; expected read data go into another.
// The monitor checks the outputs on every cycle and pops read data on each ack.
module tb_rb1_arbiter;

    localparam int BURST_MAX = 18;

    logic       clk = 1'b0;
    logic       rst, req0, req1, rw0, rw1;
    logic [4:0] a0, a1;
    logic [7:0] d0, d1;
    logic       gnt0, gnt1, ack0, ack1;
    logic [7:0] q;
    logic       RB1_RW;
    logic [4:0] RB1_A;
    logic [7:0] RB1_D;
    logic [7:0] RB1_Q;

    rb1_arbiter #(.BURST_MAX(BURST_MAX)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
        .a0(a0), .a1(a1), .d0(d0), .d1(d1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1), .q(q),
        .RB1_RW(RB1_RW), .RB1_A(RB1_A), .RB1_D(RB1_D), .RB1_Q(RB1_Q)
    );

    always #5 clk = ~clk;

    // Bank model: synchronous write, read data registered one cycle after the address
    logic       bank_load;
    logic [7:0] bank [0:31];
    always @(posedge clk) begin
        if (bank_load) begin
            for (int i = 0; i < 32; i++) bank[i] <= 8'(8'h10 + i);
        end else begin
            if (RB1_RW == 1'b0) bank[RB1_A] <= RB1_D;
            RB1_Q <= bank[RB1_A];
        end
    end

    typedef struct packed {
        logic       gnt0;
        logic       gnt1;
        logic       ack0;
        logic       ack1;
        logic       rw;
        logic [4:0] a;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        int         who;
        logic [7:0] data;
    } ack_t;

    exp_t cyc_q [$];
    ack_t ack_q [$];

    int n_vec = 0;
    int n_mis = 0;

    // Reference model state
    int         m_owner = -1;
    int         m_cnt   = 0;
    int         m_last  = 1;
    int         m_pend  = -1;
    int         acc_who = -1;
    logic [7:0] ref_mem [0:31];

    // Drive one cycle of stimulus, then advance the model and push its expectations
    task automatic cyc(input bit r, input bit rq0, input bit rq1, input bit w0, input bit w1,
                       input logic [4:0] x0, input logic [4:0] x1,
                       input logic [7:0] y0, input logic [7:0] y1);
        bit         rq [2];
        bit         wv [2];
        logic [4:0] av [2];
        logic [7:0] dv [2];
        exp_t       e;
        ack_t       k;
        int         nxt_pend;
        int         oth;
        @(negedge clk);
        rst = r; req0 = rq0; req1 = rq1; rw0 = w0; rw1 = w1;
        a0 = x0; a1 = x1; d0 = y0; d1 = y1;
        rq[0] = rq0; rq[1] = rq1; wv[0] = w0; wv[1] = w1;
        av[0] = x0; av[1] = x1; dv[0] = y0; dv[1] = y1;

        e.gnt0 = (m_owner == 0);
        e.gnt1 = (m_owner == 1);
        e.ack0 = (m_pend == 0);
        e.ack1 = (m_pend == 1);
        e.rw = 1'b1; e.a = 5'd0; e.d = 8'd0;
        nxt_pend = -1;
        acc_who  = -1;

        if (r) begin
            m_owner = -1; m_cnt = 0; m_last = 1;
        end else begin
            if (m_owner >= 0 && rq[m_owner]) begin
                acc_who = m_owner;
                e.rw = wv[m_owner]; e.a = av[m_owner]; e.d = dv[m_owner];
                if (e.rw) begin
                    k.who = m_owner; k.data = ref_mem[e.a];
                    ack_q.push_back(k);
                    nxt_pend = m_owner;
                end else begin
                    ref_mem[e.a] = e.d;
                end
                if (m_cnt < BURST_MAX) m_cnt++;
            end
            if (m_owner < 0) begin
                m_cnt = 0;
                if (rq0 && rq1) m_owner = 1 - m_last;
                else if (rq0)   m_owner = 0;
                else if (rq1)   m_owner = 1;
            end else begin
                oth = 1 - m_owner;
                if (!rq[m_owner] || (rq[oth] && m_cnt == BURST_MAX)) begin
                    m_last  = m_owner;
                    m_cnt   = 0;
                    m_owner = rq[oth] ? oth : -1;
                end
            end
        end
        m_pend = nxt_pend;
        cyc_q.push_back(e);
    endtask

    // Monitor: per-cycle output check plus read-data scoreboard on every ack
    initial begin
        exp_t e, obs;
        ack_t k;
        forever begin
            @(negedge clk);
            #2;
            if (cyc_q.size() > 0) begin
                e   = cyc_q.pop_front();
                obs = {gnt0, gnt1, ack0, ack1, RB1_RW, RB1_A, RB1_D};
                n_vec++;
                if (obs !== e) begin
                    n_mis++;
                    $display("FAIL cycle_outputs t=%0t got gnt=%b%b ack=%b%b rw=%b a=%0d d=%h, expected gnt=%b%b ack=%b%b rw=%b a=%0d d=%h",
                             $time, obs.gnt0, obs.gnt1, obs.ack0, obs.ack1, obs.rw, obs.a, obs.d,
                             e.gnt0, e.gnt1, e.ack0, e.ack1, e.rw, e.a, e.d);
                end
            end
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
                n_vec++;
                if (ack_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL ack_unexpected t=%0t got ack=%b%b, expected no ack", $time, ack0, ack1);
                end else begin
                    k = ack_q.pop_front();
                    if ((ack1 ? 1 : 0) != k.who || q !== k.data) begin
                        n_mis++;
                        $display("FAIL ack_data t=%0t got who=%0d q=%h, expected who=%0d q=%h",
                                 $time, ack1 ? 1 : 0, q, k.who, k.data);
                    end
                end
            end
        end
    end

    initial begin
        int ad, n0, n1, g;
        bit r0, r1;
        rst = 1'b1; req0 = 0; req1 = 0; rw0 = 1; rw1 = 1;
        a0 = 0; a1 = 0; d0 = 0; d1 = 0;
        bank_load = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'(8'h10 + i);
        repeat (2) @(posedge clk);
        bank_load = 1'b0;

        // Reset, then simultaneous requests: requester 0 must win
        cyc(1, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 5'd4, 5'd9, 0, 0);
        cyc(0, 1, 1, 1, 1, 5'd4, 5'd9, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Requester 0 reads addresses 0..17 back to back
        ad = 0;
        for (g = 0; g < 60 && ad < 18; g++) begin
            cyc(0, 1, 0, 1, 1, 5'(ad), 0, 0, 0);
            if (acc_who == 0) ad++;
        end
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Requester 1 writes A5 to address 3, then reads it back
        for (g = 0; g < 10; g++) begin
            cyc(0, 0, 1, 1, 0, 0, 5'd3, 0, 8'hA5);
            if (acc_who == 1) break;
        end
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (g = 0; g < 10; g++) begin
            cyc(0, 0, 1, 1, 1, 0, 5'd3, 0, 0);
            if (acc_who == 1) break;
        end
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Long read burst by 0 with 1 waiting: forced handover, then 0 regains the bank
        n0 = 0; n1 = 0;
        for (g = 0; g < 120 && (n0 < 25 || n1 < 4); g++) begin
            cyc(0, n0 < 25, n1 < 4, 1, 1, 5'(n0 % 18), 5'(n1), 0, 0);
            if (acc_who == 0) n0++;
            if (acc_who == 1) n1++;
        end
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Reset in the middle of a write burst (counter at 7, write to 20 pending)
        n0 = 0;
        for (g = 0; g < 30 && n0 < 7; g++) begin
            cyc(0, 1, 0, 0, 1, 5'(8 + n0), 0, 8'($urandom), 0);
            if (acc_who == 0) n0++;
        end
        cyc(1, 1, 0, 0, 1, 5'd20, 0, 8'hEE, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (g = 0; g < 10; g++) begin
            cyc(0, 0, 1, 1, 1, 0, 5'd20, 0, 0);
            if (acc_who == 1) break;
        end
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Randomized traffic, including addresses above 17 and occasional resets
        r0 = 0; r1 = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) r0 = !r0;
            if ($urandom_range(0, 5) == 0) r1 = !r1;
            cyc($urandom_range(0, 199) == 0, r0, r1,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                8'($urandom), 8'($urandom));
        end
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        #4;

        n_vec++;
        if (ack_q.size() != 0) begin
            n_mis++;
            $display("FAIL ack_drain got %0d reads never acknowledged, expected 0", ack_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
